// File: rtl/sfx_pkg.sv
// sfx_pkg: note table, effect ROM and divider helpers shared by the sound-effect sequencer.
package sfx_pkg;
    typedef enum logic [2:0] {N_REST, N_C4, N_C5, N_E5, N_G5, N_C6} note_e;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_FINISH} state_e;
    typedef struct packed {
        note_e      note;
        logic [3:0] units;
    } step_t;
    localparam int F_C4 = 262;
    localparam int F_C5 = 523;
    localparam int F_E5 = 659;
    localparam int F_G5 = 784;
    localparam int F_C6 = 1047;
    function automatic int note_hz(logic [2:0] n);
        return n == N_C4 ? F_C4 : n == N_C5 ? F_C5 : n == N_E5 ? F_E5 :
               n == N_G5 ? F_G5 : n == N_C6 ? F_C6 : 0;
    endfunction
    function automatic logic [17:0] half_cyc(int clk_hz, logic [2:0] n);
        int f;
        f = note_hz(n);
        return f == 0 ? 18'd0 : 18'(clk_hz / (2 * f));
    endfunction
    function automatic int unit_cyc(int clk_hz, int unit_ms);
        return clk_hz / 1000 * unit_ms;
    endfunction
    // a step with zero units ends the effect
    function automatic step_t sfx_step(logic [2:0] code, logic [1:0] idx);
        step_t s;
        s = '{N_REST, 4'd0};
        case ({code, idx})
            5'b001_00: s = '{N_C5, 4'd1};
            5'b010_00: s = '{N_E5, 4'd1};
            5'b010_01: s = '{N_G5, 4'd1};
            5'b011_00: s = '{N_G5, 4'd1};
            5'b011_01: s = '{N_C5, 4'd2};
            5'b100_00: s = '{N_C4, 4'd3};
            5'b101_00: s = '{N_C6, 4'd1};
            5'b101_01: s = '{N_REST, 4'd1};
            5'b101_10: s = '{N_C6, 4'd1};
            5'b110_00: s = '{N_C5, 4'd2};
            5'b110_01: s = '{N_E5, 4'd2};
            5'b110_10: s = '{N_G5, 4'd2};
            5'b110_11: s = '{N_C6, 4'd4};
            5'b111_00: s = '{N_G5, 4'd2};
            5'b111_01: s = '{N_E5, 4'd2};
            5'b111_10: s = '{N_C5, 4'd4};
            default:   s = '{N_REST, 4'd0};
        endcase
        return s;
    endfunction
endpackage

// File: rtl/sfx_if.sv
// sfx_if: trigger and audio status bundle between game logic (master) and sequencer (slave).
interface sfx_if;
    logic [2:0] sound_code;
    logic       play_sound;
    logic       pwm;
    logic       busy;
    logic       done;
    modport master (output sound_code, play_sound, input pwm, busy, done);
    modport slave (input sound_code, play_sound, output pwm, busy, done);
endinterface

// File: rtl/sfx_tone_gen.sv
// sfx_tone_gen: free-running half-period square-wave divider, restarted high (or muted) by load.
module sfx_tone_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [17:0] half,
    input  logic        mute,
    output logic        sq
);
    logic [17:0] cnt_q, cnt_d, half_q, half_d;
    logic        sq_q, sq_d, mute_q, mute_d;
    logic        wrap;
    always_comb begin
        wrap   = cnt_q == half_q - 18'd1;
        half_d = load ? half : half_q;
        mute_d = load ? mute : mute_q;
        cnt_d  = (load || wrap) ? '0 : cnt_q + 18'd1;
        sq_d   = load ? !mute : (wrap && !mute_q) ? !sq_q : sq_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            half_q <= '0;
            mute_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            mute_q <= mute_d;
            sq_q   <= sq_d;
        end
    end
    assign sq = sq_q;
endmodule

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays a fixed note sequence per sound code as a square wave on pwm.
import sfx_pkg::*;
module sfx_sequencer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int UNIT_MS = 50
) (
    input logic clk,
    input logic rst,
    sfx_if.slave bus
);
    localparam int UNIT = unit_cyc(CLK_HZ, UNIT_MS);
    localparam int DW   = $clog2(15 * UNIT);
    state_e        state_q, state_d;
    logic [2:0]    step_q, step_d, code_q, code_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [17:0]   half_tab [8];
    step_t         cur;
    logic          fin, tone_load, sq;
    for (genvar g = 0; g < 8; g++) begin : g_half
        assign half_tab[g] = half_cyc(CLK_HZ, 3'(g));
    end
    assign cur = sfx_step(code_q, step_q[1:0]);
    assign fin = step_q[2] || cur.units == 4'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            code_q  <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            code_q  <= code_d;
            dur_q   <= dur_d;
        end
    end
    // a trigger preempts any state, including the FINISH cycle
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        code_d  = code_q;
        dur_d   = dur_q;
        if (bus.play_sound) begin
            code_d  = bus.sound_code;
            step_d  = '0;
            state_d = bus.sound_code == 3'd0 ? S_IDLE : S_LOAD;
        end else if (state_q == S_LOAD) begin
            state_d = fin ? S_FINISH : S_PLAY;
            dur_d   = DW'(int'(cur.units) * UNIT - 1);
        end else if (state_q == S_PLAY) begin
            dur_d = dur_q - DW'(1);
            if (dur_q == '0) begin
                state_d = S_LOAD;
                step_d  = step_q + 3'd1;
            end
        end else if (state_q == S_FINISH) begin
            state_d = S_IDLE;
        end
    end
    always_comb begin
        tone_load = state_q == S_LOAD;
        bus.busy  = state_q == S_LOAD || state_q == S_PLAY;
        bus.done  = state_q == S_FINISH && !bus.play_sound;
        bus.pwm   = state_q == S_PLAY && sq;
    end
    sfx_tone_gen u_tone (
        .clk  (clk),
        .rst  (rst),
        .load (tone_load),
        .half (half_tab[cur.note]),
        .mute (cur.note == N_REST),
        .sq   (sq)
    );
endmodule
